panda_instr_enc: RTL and testbench

RV32I instruction encoder with an output FIFO. It takes field-level encode requests (format, opcode, register addresses, funct fields, full 32-bit immediate) over a valid/ready handshake. It assembles the 32-bit instruction word with the exact field and immediate bit placement that the core's decoder unpacks, then queues the word for a downstream consumer. It sits in front of the core as the instruction source for the self-test and boot-stub generator and the debug instruction injector. It flags immediates that cannot be represented in the chosen format.

---
 rtl/panda_instr_enc.sv | 155 +++++++++++++++
 tb/tb_panda_instr_enc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_instr_enc.sv
// panda_instr_enc: RV32I field-level instruction encoder feeding an output FIFO.
// Requests are encoded combinationally and pushed together with an error bit.
// An unencodable request is replaced by the canonical NOP (addi x0,x0,0).
module panda_instr_enc #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_fmt_i,
  input  logic [6:0]  req_opcode_i,
  input  logic [4:0]  req_rd_i,
  input  logic [4:0]  req_rs1_i,
  input  logic [4:0]  req_rs2_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [6:0]  req_funct7_i,
  input  logic [31:0] req_imm_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        instr_err_o,
  output logic [7:0]  err_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [7:0]    err_cnt_reg;
  logic [31:0]   word_mem_reg [DEPTH];
  logic          err_mem_reg  [DEPTH];

  logic [31:0] enc_word;
  logic        enc_err;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  // Representability of the immediate for each format: upper bits must be a
  // pure sign extension of the top encodable bit, and branch/jump offsets even.
  logic imm_i_ok;
  logic imm_b_ok;
  logic imm_u_ok;
  logic imm_j_ok;

  assign imm_i_ok = (req_imm_i[31:11] == {21{req_imm_i[11]}});
  assign imm_b_ok = !req_imm_i[0] && (req_imm_i[31:12] == {20{req_imm_i[12]}});
  assign imm_u_ok = (req_imm_i[11:0] == 12'h000);
  assign imm_j_ok = !req_imm_i[0] && (req_imm_i[31:20] == {12{req_imm_i[20]}});

  // Assemble the instruction word with the decoder's field placement.
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b0;
    case (req_fmt_i)
      FMT_R: begin
        enc_word = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i,
                    req_rd_i, req_opcode_i};
      end
      FMT_I: begin
        enc_word = {req_imm_i[11:0], req_rs1_i, req_funct3_i,
                    req_rd_i, req_opcode_i};
        enc_err  = !imm_i_ok;
      end
      FMT_S: begin
        enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                    req_imm_i[4:0], req_opcode_i};
        enc_err  = !imm_i_ok;
      end
      FMT_B: begin
        enc_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i,
                    req_funct3_i, req_imm_i[4:1], req_imm_i[11], req_opcode_i};
        enc_err  = !imm_b_ok;
      end
      FMT_U: begin
        enc_word = {req_imm_i[31:12], req_rd_i, req_opcode_i};
        enc_err  = !imm_u_ok;
      end
      FMT_J: begin
        enc_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11],
                    req_imm_i[19:12], req_rd_i, req_opcode_i};
        enc_err  = !imm_j_ok;
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
    if (enc_err) begin
      enc_word = NOP_WORD;
    end
  end

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // Ready is gated by reset so it drops the instant reset is asserted.
  assign req_ready_o   = !full && !rst_i;
  assign instr_valid_o = !empty;
  assign push          = req_valid_i && req_ready_o;
  assign pop           = instr_valid_o && instr_ready_i;

  assign instr_o     = word_mem_reg[rd_ptr_reg[AW-1:0]];
  assign instr_err_o = err_mem_reg[rd_ptr_reg[AW-1:0]];
  assign err_cnt_o   = err_cnt_reg;

  // FIFO storage; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem_reg[i] <= 32'h0;
        err_mem_reg[i]  <= 1'b0;
      end
    end else if (push) begin
      word_mem_reg[wr_ptr_reg[AW-1:0]] <= enc_word;
      err_mem_reg[wr_ptr_reg[AW-1:0]]  <= enc_err;
    end
  end

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

  // Saturating count of accepted unencodable requests.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_reg <= 8'h00;
    end else if (push && enc_err && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'h01;
    end
  end

endmodule

// File: tb/tb_panda_instr_enc.sv
// Directed-vector bench for panda_instr_enc with hand-computed encodings.
module tb_panda_instr_enc;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_imm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        instr_err;
  logic [7:0]  err_cnt;

  int checks;
  int failures;

  panda_instr_enc #(.DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_fmt_i    (req_fmt),
    .req_opcode_i (req_opcode),
    .req_rd_i     (req_rd),
    .req_rs1_i    (req_rs1),
    .req_rs2_i    (req_rs2),
    .req_funct3_i (req_funct3),
    .req_funct7_i (req_funct7),
    .req_imm_i    (req_imm),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .instr_o      (instr),
    .instr_err_o  (instr_err),
    .err_cnt_o    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    req_fmt    = fmt;
    req_opcode = opc;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_funct3 = f3;
    req_funct7 = f7;
    req_imm    = imm;
  endtask

  // Present the current request until accepted; returns 1 ns after the accepting edge.
  task automatic push_req(input string tag);
    int n;
    n = 0;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check_eq({tag, "_push_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Check the head word and error bit, then pop it.
  task automatic expect_pop(input string tag, input logic [31:0] word, input logic err);
    int n;
    n = 0;
    while (!instr_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check_eq({tag, "_word"}, instr, word);
    check_eq({tag, "_err"}, {31'd0, instr_err}, {31'd0, err});
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
  endtask

  function automatic logic [31:0] addi_word(input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  initial begin
    int acc;
    int n;
    logic was_ready;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    instr_ready = 1'b0;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

    #2;
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_instr_err", {31'd0, instr_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // ADDI x1,x0,5 with one-cycle latency check
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    push_req("addi");
    check_eq("addi_latency_valid", {31'd0, instr_valid}, 32'd1);
    expect_pop("addi", 32'h0050_0093, 1'b0);

    set_req(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    push_req("sw");
    expect_pop("sw", 32'h0020_A423, 1'b0);

    set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    push_req("beq");
    expect_pop("beq", 32'hFE00_0EE3, 1'b0);

    set_req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    push_req("jal");
    expect_pop("jal", 32'h0010_00EF, 1'b0);

    set_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    push_req("lui");
    expect_pop("lui", 32'h1234_52B7, 1'b0);

    // SUB x3,x1,x2 with a garbage immediate that must be ignored
    set_req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF);
    push_req("sub");
    expect_pop("sub", 32'h4020_81B3, 1'b0);

    check_eq("err_cnt_zero", {24'd0, err_cnt}, 32'd0);

    // Unencodable requests
    set_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    push_req("b_misaligned");
    expect_pop("b_misaligned", 32'h0000_0013, 1'b1);
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    push_req("i_range");
    expect_pop("i_range", 32'h0000_0013, 1'b1);
    set_req(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    push_req("fmt7");
    expect_pop("fmt7", 32'h0000_0013, 1'b1);
    check_eq("err_cnt_3", {24'd0, err_cnt}, 32'd3);

    // 260 more error pushes streamed with the consumer always ready
    instr_ready = 1'b1;
    req_valid = 1'b1;
    repeat (260) @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
    n = 0;
    while (instr_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    instr_ready = 1'b0;
    check_eq("drain_empty", {31'd0, instr_valid}, 32'd0);

    // Fill with the consumer stalled: exactly DEPTH accepted
    acc = 0;
    req_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(acc + 10));
      was_ready = req_ready;
      @(posedge clk);
      #1;
      if (was_ready) acc++;
    end
    req_valid = 1'b0;
    check_eq("full_accepted", 32'(acc), 32'd4);
    check_eq("full_ready_low", {31'd0, req_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      expect_pop($sformatf("fill_pop%0d", k), addi_word(12'(k + 10)), 1'b0);
    end

    // Two queued, then simultaneous push and pop keeps occupancy at 2
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd20);
    push_req("q0");
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd21);
    push_req("q1");
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd22);
    check_eq("pp_head_before", instr, addi_word(12'd20));
    req_valid = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    instr_ready = 1'b0;
    expect_pop("pp_a", addi_word(12'd21), 1'b0);
    expect_pop("pp_b", addi_word(12'd22), 1'b0);
    check_eq("pp_empty", {31'd0, instr_valid}, 32'd0);

    // Pointer wrap: many sequential push/pop pairs stay in order
    for (int k = 0; k < 10; k++) begin
      set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(100 + k));
      push_req("wrap");
      expect_pop($sformatf("wrap%0d", k), addi_word(12'(100 + k)), 1'b0);
    end

    // Asynchronous reset with 3 queued words
    for (int k = 0; k < 3; k++) begin
      set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(200 + k));
      push_req("pre_rst");
    end
    check_eq("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("async_rst_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("after_rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("after_rst_empty", {31'd0, instr_valid}, 32'd0);
    check_eq("after_rst_err_cnt", {24'd0, err_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
